// File: rtl/systolic_ctrl.sv
// systolic_ctrl: holds host-loaded A/B, streams skewed operands into a DIM x DIM output-stationary array, captures C and returns it one row per handshake (host: ld_*/start/busy/done/err/res_*, array: arr_*)
module systolic_ctrl #(
  parameter int DATA_W  = 16,
  parameter int DIM     = 3,
  parameter int TIMEOUT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_en,
  input  logic                        ld_sel,
  input  logic [$clog2(DIM)-1:0]      ld_row,
  input  logic [DIM*DATA_W-1:0]       ld_data,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        arr_rst_n,
  output logic [DIM*DATA_W-1:0]       arr_a,
  output logic [DIM*DATA_W-1:0]       arr_b,
  output logic                        arr_valid,
  input  logic [DIM*DIM*2*DATA_W-1:0] arr_c,
  input  logic                        arr_valid_out,
  output logic [DIM*2*DATA_W-1:0]     res_data,
  output logic [$clog2(DIM)-1:0]      res_row,
  output logic                        res_valid,
  output logic                        res_last,
  input  logic                        res_ready
);
  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(TIMEOUT + 2*DIM);
  localparam int RS = DIM*2*DATA_W;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUT} state_t;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_W-1:0]     r_a [DIM][DIM];
  logic [DATA_W-1:0]     r_b [DIM][DIM];
  logic [RS-1:0]         r_c [DIM];
  logic [CW-1:0]         w_cnt_nxt;
  logic [DIM*DATA_W-1:0] w_a;
  logic [DIM*DATA_W-1:0] w_b;
  logic                  w_cap;
  logic                  w_feed_end;
  assign busy       = r_state != S_IDLE;
  assign res_last   = res_valid && res_row == RW'(DIM-1);
  assign res_data   = res_valid ? r_c[res_row] : '0;
  assign w_feed_end = r_cnt == CW'(2*DIM-2);
  assign w_cap      = r_state == S_DRAIN && (arr_valid_out || r_cnt == CW'(TIMEOUT-1));
  // operands are registered one cycle ahead, so the skew is computed for the count about to be shown
  always_comb begin
    w_cnt_nxt = r_state == S_CLEAR ? '0 : r_cnt + 1'b1;
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++)
        if (CW'(i + k) == w_cnt_nxt) begin
          w_a[i*DATA_W +: DATA_W] = r_a[i][k];
          w_b[i*DATA_W +: DATA_W] = r_b[k][i];
        end
  end
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && ld_en)
      for (int k = 0; k < DIM; k++)
        if (ld_sel) r_b[ld_row][k] <= ld_data[k*DATA_W +: DATA_W];
        else r_a[ld_row][k] <= ld_data[k*DATA_W +: DATA_W];
    if (w_cap)
      for (int i = 0; i < DIM; i++) r_c[i] <= arr_c[i*RS +: RS];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      arr_rst_n <= 1'b0;
      arr_a     <= '0;
      arr_b     <= '0;
      arr_valid <= 1'b0;
      res_valid <= 1'b0;
      res_row   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          arr_rst_n <= !start;
          if (start) begin
            err     <= 1'b0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          arr_rst_n <= 1'b1;
          arr_valid <= 1'b1;
          arr_a     <= w_a;
          arr_b     <= w_b;
          r_cnt     <= '0;
          r_state   <= S_FEED;
        end
        S_FEED: begin
          arr_valid <= !w_feed_end;
          arr_a     <= w_feed_end ? '0 : w_a;
          arr_b     <= w_feed_end ? '0 : w_b;
          r_cnt     <= w_feed_end ? '0 : w_cnt_nxt;
          r_state   <= w_feed_end ? S_DRAIN : S_FEED;
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_cap) begin
            err       <= !arr_valid_out;
            res_valid <= 1'b1;
            res_row   <= '0;
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_row <= res_last ? '0 : res_row + 1'b1;
            if (res_last) begin
              res_valid <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed self-checking bench for systolic_ctrl
module tb_systolic_ctrl;
  localparam int W = 16;
  localparam int D = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_en = 1'b0;
  logic ld_sel = 1'b0;
  logic [1:0] ld_row = '0;
  logic [D*W-1:0] ld_data = '0;
  logic start = 1'b0;
  logic res_ready = 1'b0;
  logic arr_valid_out = 1'b0;
  logic [D*D*2*W-1:0] arr_c = '0;
  logic busy, done, err, arr_rst_n, arr_valid, res_valid, res_last;
  logic [D*W-1:0] arr_a, arr_b;
  logic [D*2*W-1:0] res_data;
  logic [1:0] res_row;
  int tests = 0;
  int fails = 0;
  int hs = 0;
  int hs0, n;
  logic [D*D*2*W-1:0] prod;
  systolic_ctrl #(.DATA_W(W), .DIM(D), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .err(err), .arr_rst_n(arr_rst_n),
    .arr_a(arr_a), .arr_b(arr_b), .arr_valid(arr_valid), .arr_c(arr_c),
    .arr_valid_out(arr_valid_out), .res_data(res_data), .res_row(res_row),
    .res_valid(res_valid), .res_last(res_last), .res_ready(res_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (res_valid && res_ready) hs++;
  function automatic logic [D*W-1:0] v3(int a, int b, int c);
    return {c[W-1:0], b[W-1:0], a[W-1:0]};
  endfunction
  function automatic logic [D*2*W-1:0] r3(int a, int b, int c);
    return {c[31:0], b[31:0], a[31:0]};
  endfunction
  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic chk1(string tag, logic o, logic e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  task automatic ld(logic sel, logic [1:0] row, logic [D*W-1:0] d);
    ld_en = 1'b1;
    ld_sel = sel;
    ld_row = row;
    ld_data = d;
    step;
    ld_en = 1'b0;
  endtask
  task automatic feed(string tag, logic [D*W-1:0] ea, logic [D*W-1:0] eb);
    chk1({tag, "_valid"}, arr_valid, 1'b1);
    chk1({tag, "_rstn"}, arr_rst_n, 1'b1);
    chk({tag, "_a"}, 128'(arr_a), 128'(ea));
    chk({tag, "_b"}, 128'(arr_b), 128'(eb));
  endtask
  task automatic row(string tag, logic [1:0] r, logic [D*2*W-1:0] d, logic last);
    chk1({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_row"}, 128'(res_row), 128'(r));
    chk({tag, "_data"}, 128'(res_data), 128'(d));
    chk1({tag, "_last"}, res_last, last);
  endtask
  initial begin
    prod = {r3(138, 114, 90), r3(84, 69, 54), r3(30, 24, 18)};
    step;
    step;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_arr_rst_n", arr_rst_n, 1'b0);
    chk1("rst_arr_valid", arr_valid, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_row", 128'(res_row), 128'(0));
    chk("rst_res_data", 128'(res_data), 128'(0));
    chk("rst_arr_a", 128'(arr_a), 128'(0));
    chk("rst_arr_b", 128'(arr_b), 128'(0));
    rst = 1'b0;
    step;
    chk1("idle_rstn", arr_rst_n, 1'b1);
    ld(1'b0, 2'd0, v3(1, 2, 3));
    ld(1'b0, 2'd1, v3(4, 5, 6));
    ld(1'b0, 2'd2, v3(7, 8, 9));
    ld(1'b1, 2'd0, v3(9, 8, 7));
    ld(1'b1, 2'd1, v3(6, 5, 4));
    start = 1'b1;
    ld(1'b1, 2'd2, v3(3, 2, 1));
    start = 1'b0;
    chk1("clr_rstn", arr_rst_n, 1'b0);
    chk1("clr_valid", arr_valid, 1'b0);
    chk1("clr_busy", busy, 1'b1);
    step;
    feed("f0", v3(1, 0, 0), v3(9, 0, 0));
    step;
    feed("f1", v3(2, 4, 0), v3(6, 8, 0));
    ld_en = 1'b1;
    ld_sel = 1'b0;
    ld_row = 2'd0;
    ld_data = v3(99, 99, 99);
    start = 1'b1;
    step;
    ld_en = 1'b0;
    start = 1'b0;
    feed("f2", v3(3, 5, 7), v3(3, 5, 7));
    step;
    feed("f3", v3(0, 6, 8), v3(0, 2, 4));
    step;
    feed("f4", v3(0, 0, 9), v3(0, 0, 1));
    step;
    chk1("d0_valid", arr_valid, 1'b0);
    chk("d0_a", 128'(arr_a), 128'(0));
    chk("d0_b", 128'(arr_b), 128'(0));
    chk1("d0_res_valid", res_valid, 1'b0);
    step;
    chk1("d1_res_valid", res_valid, 1'b0);
    arr_c = prod;
    arr_valid_out = 1'b1;
    step;
    arr_valid_out = 1'b0;
    arr_c = '1;
    hs0 = hs;
    row("r0", 2'd0, r3(30, 24, 18), 1'b0);
    res_ready = 1'b1;
    step;
    row("r1", 2'd1, r3(84, 69, 54), 1'b0);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      row("r1_hold", 2'd1, r3(84, 69, 54), 1'b0);
    end
    res_ready = 1'b1;
    step;
    row("r2", 2'd2, r3(138, 114, 90), 1'b1);
    chk1("r2_done", done, 1'b0);
    step;
    res_ready = 1'b0;
    chk1("end_done", done, 1'b1);
    chk1("end_busy", busy, 1'b0);
    chk1("end_res_valid", res_valid, 1'b0);
    chk1("end_err", err, 1'b0);
    chk("handshakes", 128'(hs - hs0), 128'(3));
    step;
    chk1("done_pulse", done, 1'b0);
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    feed("run2_f0", v3(1, 0, 0), v3(9, 0, 0));
    step;
    step;
    feed("run2_f2", v3(3, 5, 7), v3(3, 5, 7));
    step;
    step;
    step;
    arr_c = prod;
    arr_valid_out = 1'b1;
    step;
    arr_valid_out = 1'b0;
    res_ready = 1'b1;
    row("run2_r0", 2'd0, r3(30, 24, 18), 1'b0);
    step;
    row("run2_r1", 2'd1, r3(84, 69, 54), 1'b0);
    step;
    row("run2_r2", 2'd2, r3(138, 114, 90), 1'b1);
    step;
    res_ready = 1'b0;
    chk1("run2_done", done, 1'b1);
    arr_c = {r3(7, 8, 9), r3(4, 5, 6), r3(1, 2, 3)};
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 5; i++) step;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step;
      if (res_valid) break;
      n++;
    end
    chk("to_cycles", 128'(n), 128'(32));
    chk1("to_err", err, 1'b1);
    chk("to_data", 128'(res_data), 128'(r3(1, 2, 3)));
    res_ready = 1'b1;
    step;
    step;
    step;
    res_ready = 1'b0;
    chk1("to_done", done, 1'b1);
    step;
    chk1("to_err_sticky", err, 1'b1);
    start = 1'b1;
    step;
    start = 1'b0;
    chk1("start_clr_err", err, 1'b0);
    step;
    step;
    step;
    feed("mid_f2", v3(3, 5, 7), v3(3, 5, 7));
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_valid", arr_valid, 1'b0);
    chk1("mid_done", done, 1'b0);
    chk1("mid_res_valid", res_valid, 1'b0);
    step;
    chk1("mid_done2", done, 1'b0);
    chk1("mid_busy2", busy, 1'b0);
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    feed("run3_f0", v3(1, 0, 0), v3(9, 0, 0));
    step;
    step;
    step;
    step;
    arr_c = prod;
    arr_valid_out = 1'b1;
    step;
    chk1("vo_ignored_in_feed", res_valid, 1'b0);
    step;
    arr_valid_out = 1'b0;
    res_ready = 1'b1;
    row("run3_r0", 2'd0, r3(30, 24, 18), 1'b0);
    step;
    row("run3_r1", 2'd1, r3(84, 69, 54), 1'b0);
    step;
    row("run3_r2", 2'd2, r3(138, 114, 90), 1'b1);
    step;
    res_ready = 1'b0;
    chk1("run3_done", done, 1'b1);
    chk1("run3_err", err, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
